btn_event_decoder: RTL and testbench



---
 rtl/btn_event_decoder.sv | 162 ++++++++++++++++
 tb/tb_btn_event_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies debounced button gestures into short, double and long press pulses.
//
// Ports:
//   iClk     system clock
//   iRst     asynchronous active-high reset
//   iBtn     debounced button level (1 = pressed), synchronous to iClk
//   oShort   single-cycle short-press pulse
//   oDouble  single-cycle double-press pulse
//   oLong    single-cycle long-press pulse
//   oRepeat  single-cycle auto-repeat pulse while held after a long press
//   oBusy    high whenever the FSM is not in IDLE
//   oState   current state encoding (debug)
//
// Optional feature: define BTN_AUTO_REPEAT_EN to enable oRepeat; otherwise it is tied 0.
module btn_event_decoder #(
    parameter int TICK_DIV  = 100_000,
    parameter int LONG_MS   = 1000,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iBtn,
    output logic       oShort,
    output logic       oDouble,
    output logic       oLong,
    output logic       oRepeat,
    output logic       oBusy,
    output logic [2:0] oState
);
    localparam int M1     = LONG_MS > DOUBLE_MS ? LONG_MS : DOUBLE_MS;
    localparam int MAX_MS = M1 > REPEAT_MS ? M1 : REPEAT_MS;
    localparam int CW     = $clog2(MAX_MS) + 1;
    localparam int PW     = $clog2(TICK_DIV);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;
    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [CW-1:0] r_ticks;
    logic          rBtn_d;
    logic          r_short;
    logic          r_double;
    logic          r_long;
    logic          w_rise;
    logic          w_fall;
    logic          w_tick;
    logic          w_long;
    logic          w_dbl_to;
    assign w_rise   = iBtn & ~rBtn_d;
    assign w_fall   = ~iBtn & rBtn_d;
    assign w_tick   = r_pre == PW'(TICK_DIV - 1);
    // Threshold N is met on the tick that would bring the tick count to N,
    // i.e. exactly N*TICK_DIV cycles after entering the state.
    assign w_long   = w_tick && r_ticks == CW'(LONG_MS - 1);
    assign w_dbl_to = w_tick && r_ticks == CW'(DOUBLE_MS - 1);
`ifdef BTN_AUTO_REPEAT_EN
    logic r_repeat;
    logic w_repeat;
    assign w_repeat = w_tick && r_ticks == CW'(REPEAT_MS - 1);
    assign oRepeat  = r_repeat;
`else
    assign oRepeat  = 1'b0;
`endif
    assign oShort  = r_short;
    assign oDouble = r_double;
    assign oLong   = r_long;
    assign oBusy   = r_state != IDLE;
    assign oState  = r_state;
    // Each transition also clears the prescaler and tick counter so every
    // timeout is measured from state entry.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state  <= IDLE;
            r_pre    <= '0;
            r_ticks  <= '0;
            rBtn_d   <= 1'b1;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            r_repeat <= 1'b0;
`endif
        end else begin
            rBtn_d   <= iBtn;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            r_repeat <= 1'b0;
`endif
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            r_ticks  <= w_tick ? r_ticks + 1'b1 : r_ticks;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESS1;
                        r_pre   <= '0;
                        r_ticks <= '0;
                    end
                end
                PRESS1: begin
                    // A release landing on the threshold cycle wins over the long press.
                    if (w_fall) begin
                        r_state <= WAIT2;
                        r_pre   <= '0;
                        r_ticks <= '0;
                    end else if (w_long && iBtn) begin
                        r_state <= HOLD;
                        r_long  <= 1'b1;
                        r_pre   <= '0;
                        r_ticks <= '0;
                    end
                end
                WAIT2: begin
                    // A second press landing on the timeout cycle still counts as a double.
                    if (w_rise) begin
                        r_state <= PRESS2;
                        r_pre   <= '0;
                        r_ticks <= '0;
                    end else if (w_dbl_to) begin
                        r_state <= IDLE;
                        r_short <= 1'b1;
                        r_pre   <= '0;
                        r_ticks <= '0;
                    end
                end
                PRESS2: begin
                    if (w_fall) begin
                        r_state  <= IDLE;
                        r_double <= 1'b1;
                        r_pre    <= '0;
                        r_ticks  <= '0;
                    end
                end
                HOLD: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                        r_pre   <= '0;
                        r_ticks <= '0;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (w_repeat) begin
                        r_repeat <= 1'b1;
                        r_pre    <= '0;
                        r_ticks  <= '0;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_pre   <= '0;
                    r_ticks <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: table-driven gesture bench with a pulse scoreboard for btn_event_decoder.
module tb_btn_event_decoder;
    localparam logic [3:0] EV_N = 4'b0000;
    localparam logic [3:0] EV_S = 4'b1000;
    localparam logic [3:0] EV_D = 4'b0100;
    localparam logic [3:0] EV_L = 4'b0010;
    localparam logic [3:0] EV_R = 4'b0001;
    typedef struct {
        int         p1;
        int         g;
        int         p2;
        int         st;
        logic [3:0] ev1;
        int         off1;
        logic [3:0] ev2;
        int         off2;
    } row_t;
    typedef struct {
        logic [3:0] ev;
        int         cyc;
    } exp_t;
    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iBtn = 1'b0;
    logic       oShort;
    logic       oDouble;
    logic       oLong;
    logic       oRepeat;
    logic       oBusy;
    logic [2:0] oState;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       sb[$];
    row_t       rows[9];
    btn_event_decoder #(
        .TICK_DIV (10),
        .LONG_MS  (5),
        .DOUBLE_MS(3),
        .REPEAT_MS(2)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iBtn   (iBtn),
        .oShort (oShort),
        .oDouble(oDouble),
        .oLong  (oLong),
        .oRepeat(oRepeat),
        .oBusy  (oBusy),
        .oState (oState)
    );
    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;
    // Every pulse seen must match the oldest expected event, both kind and cycle.
    always @(negedge iClk) begin
        logic [3:0] got;
        exp_t       e;
        got = {oShort, oDouble, oLong, oRepeat};
        if (got != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected got %b at cycle %0d want none", got, cyc);
            end else begin
                e = sb.pop_front();
                if (got !== e.ev || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse got %b at cycle %0d want %b at cycle %0d", got, cyc, e.ev, e.cyc);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask
    task automatic apply(input row_t r, input int idx);
        int c0;
        c0 = cyc;
        sb.push_back(exp_t'{r.ev1, c0 + r.off1});
        if (r.ev2 != EV_N) sb.push_back(exp_t'{r.ev2, c0 + r.off2});
`ifdef BTN_AUTO_REPEAT_EN
        if (r.ev1 == EV_L)
            for (int t = r.off1 + 20; t < r.p1 + 1; t += 20) sb.push_back(exp_t'{EV_R, c0 + t});
`endif
        iBtn = 1'b1;
        repeat (r.p1) @(negedge iClk);
        chk($sformatf("row%0d_mid_state", idx), {29'd0, oState}, r.st);
        iBtn = 1'b0;
        if (r.p2 > 0) begin
            repeat (r.g) @(negedge iClk);
            iBtn = 1'b1;
            repeat (r.p2) @(negedge iClk);
            iBtn = 1'b0;
        end
        repeat (70) @(negedge iClk);
        chk($sformatf("row%0d_end_state", idx), {29'd0, oState}, 0);
        chk($sformatf("row%0d_end_busy", idx), {31'd0, oBusy}, 0);
        chk($sformatf("row%0d_missing_events", idx), sb.size(), 0);
        sb.delete();
    endtask
    initial begin
        rows[0] = '{20, 0, 0, 1, EV_S, 51, EV_N, 0};
        rows[1] = '{1, 0, 0, 1, EV_S, 32, EV_N, 0};
        rows[2] = '{20, 15, 20, 1, EV_D, 56, EV_N, 0};
        rows[3] = '{120, 0, 0, 4, EV_L, 51, EV_N, 0};
        rows[4] = '{50, 0, 0, 1, EV_S, 81, EV_N, 0};
        rows[5] = '{51, 0, 0, 4, EV_L, 51, EV_N, 0};
        rows[6] = '{20, 30, 10, 1, EV_D, 61, EV_N, 0};
        rows[7] = '{20, 31, 10, 1, EV_S, 51, EV_S, 92};
        rows[8] = '{10, 10, 80, 1, EV_D, 101, EV_N, 0};
        iRst = 1'b1;
        iBtn = 1'b0;
        repeat (3) @(negedge iClk);
        chk("reset_state", {29'd0, oState}, 0);
        chk("reset_busy", {31'd0, oBusy}, 0);
        chk("reset_pulses", {28'd0, oShort, oDouble, oLong, oRepeat}, 0);
        iRst = 1'b0;
        repeat (3) @(negedge iClk);
        for (int i = 0; i < 9; i++) apply(rows[i], i);
        iBtn = 1'b1;
        repeat (20) @(negedge iClk);
        iBtn = 1'b0;
        repeat (10) @(negedge iClk);
        chk("rstA_wait2_state", {29'd0, oState}, 2);
        iRst = 1'b1;
        #1;
        chk("rstA_async_state", {29'd0, oState}, 0);
        chk("rstA_async_busy", {31'd0, oBusy}, 0);
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        repeat (50) @(negedge iClk);
        chk("rstA_idle_state", {29'd0, oState}, 0);
        iBtn = 1'b1;
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        repeat (100) @(negedge iClk);
        chk("rstB_held_state", {29'd0, oState}, 0);
        chk("rstB_held_busy", {31'd0, oBusy}, 0);
        iBtn = 1'b0;
        repeat (5) @(negedge iClk);
        apply(rows[0], 99);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
